// File: rtl/up_down_counter.sv
// ---------------------------------------------------------------------------
// up_down_counter
//
// N-bit synchronous binary up/down counter with count enable and a
// registered wrap pulse. Counts modulo 2^N; any wrap-around (2^N-1 -> 0 when
// counting up, 0 -> 2^N-1 when counting down) raises overflow for exactly
// one cycle.
//
// Ports
//   clk       in   1  rising-edge clock
//   rst       in   1  synchronous active-low reset
//   enable    in   1  1 = step this cycle, 0 = hold
//   up_down   in   1  1 = count up, 0 = count down
//   count     out  N  current counter value (registered)
//   overflow  out  1  one-cycle wrap pulse (registered)
//
// Priority at each edge: reset, then enable, then direction. Both outputs
// come straight from flops; there is no input-to-output combinational path.
// ---------------------------------------------------------------------------
module up_down_counter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         up_down,
  output logic [N-1:0] count,
  output logic         overflow
);

  localparam logic [N-1:0] CNT_MAX  = '1;
  localparam logic [N-1:0] CNT_ZERO = '0;
  localparam logic [N-1:0] CNT_ONE  = N'(1);

  logic [N-1:0] count_next;
  logic         wrap;

  // Next value and wrap detection. Carry/borrow is simply discarded by the
  // N-bit arithmetic; the wrap is detected from the pre-step value instead.
  always_comb begin
    count_next = count;
    wrap       = 1'b0;
    if (enable) begin
      if (up_down) begin
        count_next = count + CNT_ONE;
        wrap       = (count == CNT_MAX);
      end else begin
        count_next = count - CNT_ONE;
        wrap       = (count == CNT_ZERO);
      end
    end
  end

  // overflow is not sticky: it takes the wrap of this edge only, so holding
  // (enable = 0) or a non-wrapping step clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      count    <= count_next;
      overflow <= wrap;
    end
  end

endmodule

// File: tb/tb_up_down_counter.sv
// ---------------------------------------------------------------------------
// tb_up_down_counter
//
// Exercises an N=4 and an N=1 instance driven by the same inputs. Inputs are
// changed and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_up_down_counter;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       up_down = 1'b0;
  logic [3:0] count4;
  logic       ovf4;
  logic [0:0] count1;
  logic       ovf1;

  up_down_counter #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .enable(enable), .up_down(up_down),
    .count(count4), .overflow(ovf4)
  );

  up_down_counter #(.N(1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .up_down(up_down),
    .count(count1), .overflow(ovf1)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model state (plain integer arithmetic modulo 2^w)
  int m4_c = 0, m4_o = 0;
  int m1_c = 0, m1_o = 0;

  logic [4:0] exp_q[$];

  function automatic void model(input int w, input bit r, input bit e,
                                input bit u, inout int c, inout int o);
    int m;
    int t;
    m = 1 << w;
    if (!r) begin
      c = 0;
      o = 0;
    end else if (!e) begin
      o = 0;
    end else begin
      t = u ? c + 1 : c - 1;
      o = (t >= m || t < 0) ? 1 : 0;
      c = (t + m) % m;
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: apply inputs for one edge, advance models, check the N=1 instance
  task automatic step(input bit r, input bit e, input bit u);
    rst     = r;
    enable  = e;
    up_down = u;
    @(posedge clk);
    #1;
    model(4, r, e, u, m4_c, m4_o);
    model(1, r, e, u, m1_c, m1_o);
    check("n1_count", int'(count1), m1_c);
    check("n1_ovf", int'(ovf1), m1_o);
  endtask

  task automatic expect4(input string name, input int c, input int o);
    check({name, "_count"}, int'(count4), c);
    check({name, "_ovf"}, int'(ovf4), o);
  endtask

  typedef struct {
    bit r;
    bit e;
    bit u;
    int c;
    bit o;
  } vec_t;

  vec_t tbl[21];

  initial begin
    int down_c[5];
    int down_o[5];
    int c;
    int o;
    logic [4:0] exp_v;
    bit r, e, u;

    // reset held 2 cycles with enable/up active, then 19 up steps: 1..15,0,1,2,3
    tbl[0] = '{r: 1'b0, e: 1'b1, u: 1'b1, c: 0, o: 1'b0};
    tbl[1] = '{r: 1'b0, e: 1'b1, u: 1'b1, c: 0, o: 1'b0};
    for (int i = 2; i < 21; i++) begin
      tbl[i] = '{r: 1'b1, e: 1'b1, u: 1'b1, c: (i - 1) % 16, o: (i - 1 == 16)};
    end

    @(negedge clk);
    for (int i = 0; i < 21; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].u);
      expect4($sformatf("tbl%0d", i), tbl[i].c, int'(tbl[i].o));
    end

    // down wrap from 3: 2,1,0,15,14 with pulse after 0->15
    down_c = '{2, 1, 0, 15, 14};
    down_o = '{0, 0, 0, 1, 0};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0);
      expect4($sformatf("down%0d", i), down_c[i], down_o[i]);
    end

    // hold at 7 for 5 cycles, then resume up to 8
    step(1'b0, 1'b0, 1'b0);
    expect4("rst_hold", 0, 0);
    for (int i = 1; i <= 7; i++) begin
      step(1'b1, 1'b1, 1'b1);
      expect4("to7", i, 0);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b1);
      expect4("hold", 7, 0);
    end
    step(1'b1, 1'b1, 1'b1);
    expect4("resume", 8, 0);

    // direction change at 15: goes to 14, no pulse
    for (int i = 9; i <= 15; i++) begin
      step(1'b1, 1'b1, 1'b1);
      expect4("to15", i, 0);
    end
    step(1'b1, 1'b1, 1'b0);
    expect4("dir_at_max", 14, 0);

    // reset mid-run at 15 suppresses the wrap, release steps straight to 1
    step(1'b1, 1'b1, 1'b1);
    expect4("back15", 15, 0);
    step(1'b0, 1'b1, 1'b1);
    expect4("rst_mid", 0, 0);
    step(1'b1, 1'b1, 1'b1);
    expect4("rst_release", 1, 0);

    // randomized run against the reference model via expected queue
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 15) != 0);
      e = ($urandom_range(0, 3) != 0);
      u = 1'($urandom_range(0, 1));
      c = m4_c;
      o = m4_o;
      model(4, r, e, u, c, o);
      exp_q.push_back({o[0], c[3:0]});
      step(r, e, u);
      exp_v = exp_q.pop_front();
      expect4("rand", int'(exp_v[3:0]), int'(exp_v[4]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
